obi_mem_arbiter: RTL and testbench

Two-to-one OBI arbiter that shares one single-ported memory slave between the core instruction fetch port and the core data port. It sits between `cv32e40p_core` and `mm_ram` in the core testbench wrapper and replaces the separate instr and data RAM ports with one arbitrated port. Arbitration is round-robin with request locking. Responses are routed back in order through an ID FIFO that tracks outstanding transactions.

---
 rtl/obi_mem_arbiter.sv | 115 +++++++++++
 tb/tb_obi_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_arbiter.sv
// rtl/obi_mem_arbiter.sv - round-robin OBI arbiter sharing one memory port between instr fetch and data
// Request locking keeps a stalled request on the bus; an ID FIFO routes responses back in order.
module obi_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   instr_req_i,
  output logic                                   instr_gnt_o,
  input  logic [ADDR_WIDTH-1:0]                  instr_addr_i,
  output logic                                   instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]                  instr_rdata_o,
  input  logic                                   data_req_i,
  output logic                                   data_gnt_o,
  input  logic [ADDR_WIDTH-1:0]                  data_addr_i,
  input  logic                                   data_we_i,
  input  logic [DATA_WIDTH/8-1:0]                data_be_i,
  input  logic [DATA_WIDTH-1:0]                  data_wdata_i,
  output logic                                   data_rvalid_o,
  output logic [DATA_WIDTH-1:0]                  data_rdata_o,
  output logic                                   mem_req_o,
  input  logic                                   mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
  output logic                                   mem_we_o,
  output logic [DATA_WIDTH/8-1:0]                mem_be_o,
  output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
  input  logic                                   mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Source encoding everywhere: 1 = instr, 0 = data.
  logic                       prio_q;
  logic                       lock_valid_q;
  logic                       lock_src_q;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d, wr_idx;
  logic                       sel_instr, sel_req, fifo_full, fifo_empty, handshake, pop;

  always_comb begin
    sel_instr = 1'b0;
    if (lock_valid_q) begin
      sel_instr = lock_src_q;
    end else if (instr_req_i && data_req_i) begin
      sel_instr = prio_q;
    end else begin
      sel_instr = instr_req_i;
    end
  end

  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign sel_req    = sel_instr ? instr_req_i : data_req_i;
  assign mem_req_o  = sel_req & ~fifo_full;
  assign handshake  = mem_req_o & mem_gnt_i;
  assign pop        = mem_rvalid_i & ~fifo_empty;

  assign mem_addr_o  = sel_instr ? instr_addr_i : data_addr_i;
  assign mem_we_o    = sel_instr ? 1'b0 : data_we_i;
  assign mem_be_o    = sel_instr ? '1 : data_be_i;
  assign mem_wdata_o = sel_instr ? '0 : data_wdata_i;

  assign instr_gnt_o = handshake & sel_instr;
  assign data_gnt_o  = handshake & ~sel_instr;

  assign instr_rvalid_o = pop & fifo_q[0];
  assign data_rvalid_o  = pop & ~fifo_q[0];
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign outstanding_o  = cnt_q;

  // Shift FIFO with head at bit 0; a push lands one slot lower when it coincides with a pop.
  always_comb begin
    fifo_d = fifo_q;
    wr_idx = cnt_q;
    if (pop) begin
      fifo_d = fifo_q >> 1;
      wr_idx = cnt_q - CNT_W'(1);
    end
    if (handshake) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (CNT_W'(i) == wr_idx) fifo_d[i] = sel_instr;
      end
    end
    cnt_d = cnt_q + CNT_W'(handshake) - CNT_W'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q       <= 1'b0;
      lock_valid_q <= 1'b0;
      lock_src_q   <= 1'b0;
      fifo_q       <= '0;
      cnt_q        <= '0;
      err_o        <= 1'b0;
    end else begin
      fifo_q <= fifo_d;
      cnt_q  <= cnt_d;
      if (mem_rvalid_i && fifo_empty) err_o <= 1'b1;
      if (handshake) begin
        prio_q       <= ~sel_instr;
        lock_valid_q <= 1'b0;
      end else if (mem_req_o) begin
        lock_valid_q <= 1'b1;
        lock_src_q   <= sel_instr;
      end
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb/tb_obi_mem_arbiter.sv - self-checking bench for obi_mem_arbiter
// Directed scenarios followed by random OBI traffic, all compared against a queue-based reference model.
module tb_obi_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_req, instr_gnt, instr_rvalid;
  logic [AW-1:0] instr_addr;
  logic [DW-1:0] instr_rdata;
  logic          data_req, data_gnt, data_we, data_rvalid;
  logic [AW-1:0] data_addr;
  logic [3:0]    data_be;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    outstanding;
  logic          err;

  obi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_addr_i(instr_addr),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_addr_i(data_addr),
    .data_we_i(data_we), .data_be_i(data_be), .data_wdata_i(data_wdata),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .outstanding_o(outstanding), .err_o(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: outstanding transactions in grant order (1 = instr, 0 = data).
  bit q[$];
  bit m_prio, m_lock, m_lsrc, m_err;
  bit e_ig, e_dg;

  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [3:0]    s_be;
  logic [1:0]    s_out;
  logic          s_req, s_we, s_ig, s_dg, s_ir, s_dr, s_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input string tag);
    bit sel, sreq, mreq, hs, pop, exp_ir, exp_dr;
    #1;
    if (rst) begin
      q.delete();
      m_prio = 0; m_lock = 0; m_lsrc = 0; m_err = 0;
    end
    if (m_lock)                      sel = m_lsrc;
    else if (instr_req && !data_req) sel = 1;
    else if (data_req && !instr_req) sel = 0;
    else                             sel = m_prio;
    sreq = sel ? instr_req : data_req;
    mreq = sreq && (q.size() < MAXO);
    hs   = mreq && mem_gnt;
    pop  = mem_rvalid && (q.size() > 0);
    exp_ir = 0; exp_dr = 0;
    if (pop) begin
      exp_ir = q[0];
      exp_dr = !q[0];
    end
    s_addr = mem_addr; s_req = mem_req; s_we = mem_we; s_be = mem_be; s_wdata = mem_wdata;
    s_ig = instr_gnt; s_dg = data_gnt; s_ir = instr_rvalid; s_dr = data_rvalid;
    s_out = outstanding; s_err = err;
    chk({tag, ".mem_req"}, mem_req, mreq);
    if (mreq) begin
      chk({tag, ".mem_addr"}, mem_addr, sel ? instr_addr : data_addr);
      chk({tag, ".mem_we"}, mem_we, sel ? 1'b0 : data_we);
      chk({tag, ".mem_be"}, mem_be, sel ? 4'hf : data_be);
      chk({tag, ".mem_wdata"}, mem_wdata, sel ? 32'h0 : data_wdata);
    end
    chk({tag, ".instr_gnt"}, instr_gnt, hs && sel);
    chk({tag, ".data_gnt"}, data_gnt, hs && !sel);
    chk({tag, ".instr_rvalid"}, instr_rvalid, exp_ir);
    chk({tag, ".data_rvalid"}, data_rvalid, exp_dr);
    if (exp_ir) chk({tag, ".instr_rdata"}, instr_rdata, mem_rdata);
    if (exp_dr) chk({tag, ".data_rdata"}, data_rdata, mem_rdata);
    chk({tag, ".outstanding"}, outstanding, q.size());
    chk({tag, ".err"}, err, m_err);
    e_ig = hs && sel;
    e_dg = hs && !sel;
    @(posedge clk);
    if (!rst) begin
      if (mem_rvalid && q.size() == 0) m_err = 1;
      if (pop) void'(q.pop_front());
      if (hs) begin
        q.push_back(sel);
        m_prio = !sel;
        m_lock = 0;
      end else if (mreq) begin
        m_lock = 1;
        m_lsrc = sel;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    instr_req = 0; data_req = 0; data_we = 0; mem_gnt = 0;
    for (int i = 0; i < MAXO + 1; i++) begin
      mem_rvalid = (q.size() > 0);
      mem_rdata  = $urandom;
      step("drain");
    end
    mem_rvalid = 0;
  endtask

  initial begin
    rst = 1;
    instr_req = 0; instr_addr = 0; data_req = 0; data_addr = 0; data_we = 0;
    data_be = 4'hf; data_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    @(negedge clk);
    step("reset");
    chk("reset.outstanding_zero", s_out, 2'd0);
    chk("reset.mem_req_zero", s_req, 1'b0);
    rst = 0;
    step("idle");

    // Contention straight out of reset: data has priority first.
    instr_req = 1; instr_addr = 32'h80; data_req = 1; data_addr = 32'h1000; mem_gnt = 1;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = (q.size() > 0);
      mem_rdata  = $urandom;
      step("cont");
      chk($sformatf("cont.addr%0d", k), s_addr, (k % 2 == 0) ? 32'h1000 : 32'h80);
    end
    drain();

    // Lock: stalled instr request must stay on the bus while data arrives.
    instr_req = 1; instr_addr = 32'h80; data_addr = 32'h1000; mem_gnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) data_req = 1;
      step("lock");
      chk($sformatf("lock.addr%0d", k), s_addr, 32'h80);
      chk($sformatf("lock.no_dgnt%0d", k), s_dg, 1'b0);
    end
    mem_gnt = 1;
    step("lock_gnt");
    chk("lock.instr_granted", s_ig, 1'b1);
    instr_req = 0;
    mem_rvalid = 1; mem_rdata = $urandom;
    step("lock_next");
    chk("lock.data_granted", s_dg, 1'b1);
    chk("lock.data_addr", s_addr, 32'h1000);
    drain();

    // Full: two grants fill the FIFO; a pop only re-enables the request a cycle later.
    instr_req = 1; instr_addr = 32'h84; mem_gnt = 1; mem_rvalid = 0;
    step("full0");
    step("full1");
    step("full2");
    chk("full.blocked", s_req, 1'b0);
    mem_rvalid = 1; mem_rdata = $urandom;
    step("full3");
    chk("full.blocked_on_pop", s_req, 1'b0);
    mem_rvalid = 0;
    step("full4");
    chk("full.unblocked", s_req, 1'b1);
    drain();

    // Write path.
    data_req = 1; data_we = 1; data_addr = 32'h2000; data_be = 4'b0011;
    data_wdata = 32'hDEADBEEF; mem_gnt = 1;
    step("wr");
    chk("wr.we", s_we, 1'b1);
    chk("wr.be", s_be, 4'b0011);
    chk("wr.wdata", s_wdata, 32'hDEADBEEF);
    data_req = 0; data_we = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = $urandom;
    step("wr_resp");
    chk("wr.data_rvalid", s_dr, 1'b1);
    chk("wr.instr_rvalid", s_ir, 1'b0);
    mem_rvalid = 0;

    // Random traffic from OBI-compliant masters against a random-latency memory.
    for (int n = 0; n < 1500; n++) begin
      if (!instr_req || e_ig) begin
        instr_req  = ($urandom % 3) != 0;
        instr_addr = $urandom & 32'hffff_fffc;
      end
      if (!data_req || e_dg) begin
        data_req   = ($urandom % 3) != 0;
        data_addr  = $urandom;
        data_we    = $urandom;
        data_be    = $urandom;
        data_wdata = $urandom;
      end
      mem_gnt    = ($urandom % 4) != 0;
      mem_rvalid = (q.size() > 0) && ($urandom % 2 == 1);
      mem_rdata  = $urandom;
      step("rand");
    end
    drain();

    // Reset mid-traffic with two outstanding transactions.
    instr_req = 1; instr_addr = 32'h88; mem_gnt = 1;
    step("pre_rst0");
    step("pre_rst1");
    instr_req = 0;
    step("pre_rst2");
    chk("rst.outstanding_before", s_out, 2'd2);
    rst = 1;
    for (int k = 0; k < 3; k++) step("in_rst");
    rst = 0;
    step("post_rst");
    chk("rst.outstanding", s_out, 2'd0);
    chk("rst.err", s_err, 1'b0);
    instr_req = 1; data_req = 1; instr_addr = 32'h80; data_addr = 32'h1000; data_we = 0;
    step("rst_prio");
    chk("rst.prio_data_first", s_dg, 1'b1);
    instr_req = 0; data_req = 0; mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = $urandom;
    step("rst_pop");
    step("rst_spurious");
    chk("rst.spurious_no_ir", s_ir, 1'b0);
    chk("rst.spurious_no_dr", s_dr, 1'b0);
    mem_rvalid = 0;
    step("rst_err");
    chk("rst.err_set", s_err, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
